euler_result_formatter: RTL and testbench
=========================================

Name: euler_result_formatter

Overview:
- Downstream consumer for every solver core in the codebase. It takes the core's result/done/error outputs and turns them into a single ASCII line on a byte stream.
- Sequential binary-to-decimal conversion (double dabble), leading-zero suppression, optional CR/LF terminator, and an "ERR" line when the core flags failure.
- Feeds a UART transmitter or testbench sink through a valid/ready byte handshake.
- One-shot: formats one result per reset.

Parameters:
- EMIT_CRLF, 1: when 1, append 0x0D 0x0A after the digits or "ERR"; when 0, no terminator.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- result  input  32  unsigned solver result, valid while done=1
- done  input  1  level from solver; high = result/error final
- error  input  1  solver failure flag, meaningful when done=1
- tx_data  output  8  ASCII byte
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  sink accepts byte when tx_valid&&tx_ready at a clock edge
- busy  output  1  high from capture until last byte accepted
- finished  output  1  high after last byte accepted; sticky until rst

Behaviour:
- Reset values (rst=1 at an edge, any state, including mid-conversion or mid-send):
  - state=IDLE; tx_valid=0, tx_data=0, busy=0, finished=0.
  - Shift/BCD registers cleared; no partial byte is emitted after reset.
- States: IDLE, CONVERT, SKIPZ, SEND_DIGIT, SEND_ERR, SEND_CR, SEND_LF, FINISHED.
- IDLE:
  - At the first edge with done=1 (edge E0), latch result into a 32-bit shift register, clear the 40-bit BCD register (10 digits), latch error, set busy=1.
  - Next state is SEND_ERR if error=1, else CONVERT.
- CONVERT: exactly 32 cycles, 6-bit counter.
  - Each cycle, every BCD nibble >=5 gets +3.
  - Then {bcd,shift} shifts left by 1.
  - After the 32nd shift (edge E32), go to SKIPZ.
- SKIPZ: one cycle.
  - idx = index of the most significant non-zero digit (9..0); idx=0 if all digits are zero.
  - Go to SEND_DIGIT.
  - First tx_valid is visible after edge E33.
- SEND_DIGIT:
  - tx_valid=1, tx_data=0x30+bcd[idx].
  - On handshake: if idx==0, go to SEND_CR (EMIT_CRLF=1) or FINISHED; else idx decrements.
- SEND_ERR: sends 0x45, 0x52, 0x52 in order (2-bit counter), then SEND_CR or FINISHED.
- SEND_CR / SEND_LF: send 0x0D, then 0x0A, each held until its handshake.
- Handshake rules:
  - tx_valid, once high, stays high and tx_data stays stable until accepted.
  - tx_valid never depends combinationally on tx_ready.
  - Back-to-back acceptance allowed: with tx_ready held at 1, one byte per cycle.
- FINISHED:
  - tx_valid=0, busy=0, finished=1.
  - done/error/result ignored; no retransmission while done stays high.
  - Only rst returns to IDLE.
- Capture timing:
  - result/error are sampled only at E0; later changes have no effect.
  - done falling during conversion/send has no effect.
- Width rules:
  - Max value 4294967295 needs 10 digits; the BCD register never overflows.
  - Digits are always 0..9.

Test Plan:
- result=31875000, done=1, error=0, tx_ready=1 -> bytes 0x33 0x31 0x38 0x37 0x35 0x30 0x30 0x30 0x0D 0x0A ("31875000\r\n"); first tx_valid after E33; finished=1 after the LF is accepted.
- result=0 -> "0\r\n" (0x30 0x0D 0x0A). result=0xFFFFFFFF -> "4294967295\r\n" (10 digits, no truncation).
- error=1 with result=0x12345678 -> "ERR\r\n" (0x45 0x52 0x52 0x0D 0x0A); no digits emitted; CONVERT never entered.
- result=1000, tx_ready toggling pseudo-randomly (about 30% high):
  - tx_data is stable whenever tx_valid=1 and tx_ready=0.
  - Exactly "1000\r\n" is accepted.
  - EMIT_CRLF=0 variant -> "1000" only.
- rst asserted at E10 (mid-CONVERT), then again while SEND_DIGIT is stalled:
  - Next cycle: tx_valid=0, busy=0.
  - With done still 1, a fresh capture occurs and the full line is re-emitted correctly.
- After finished=1, hold done=1 and change result to 7 for 100 cycles -> tx_valid stays 0, finished stays 1.

Source files
------------

// File: rtl/euler_result_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : euler_result_formatter
//  Description : Formats one solver result as an ASCII line on a valid/ready
//                byte stream. The 32-bit result is converted to decimal with
//                a sequential double dabble, leading zeros are dropped, and a
//                CR/LF terminator is optionally appended. A failing solver
//                produces "ERR" instead of digits. One line per reset.
//  Ports       : clk       - clock, rising edge
//                rst       - synchronous active-high reset
//                result    - unsigned solver result, valid while done=1
//                done      - solver finished (level)
//                error     - solver failure flag, meaningful with done=1
//                tx_data   - ASCII byte
//                tx_valid  - tx_data is valid
//                tx_ready  - sink accepts the byte on tx_valid && tx_ready
//                busy      - capture through acceptance of the last byte
//                finished  - last byte accepted; sticky until rst
//  Revision    : 1.0 - initial release
// ============================================================================
module euler_result_formatter #(
  parameter int EMIT_CRLF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result,
  input  logic        done,
  input  logic        error,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        finished
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CONVERT    = 3'd1,
    S_SKIPZ      = 3'd2,
    S_SEND_DIGIT = 3'd3,
    S_SEND_ERR   = 3'd4,
    S_SEND_CR    = 3'd5,
    S_SEND_LF    = 3'd6,
    S_FINISHED   = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [39:0] bcd_q, bcd_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  err_cnt_q, err_cnt_d;

  logic [39:0] bcd_adj;
  logic [3:0]  digit;

  // Digit currently being sent; idx never exceeds 9, so the slice stays
  // inside the 40-bit register.
  assign digit = bcd_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    err_cnt_d = err_cnt_q;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;

    // Double dabble correction: any nibble of 5 or more gets +3 so the
    // following left shift carries correctly into the next decimal digit.
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (done) begin
          shift_d   = result;
          bcd_d     = '0;
          cnt_d     = '0;
          idx_d     = '0;
          err_cnt_d = '0;
          state_d   = error ? S_SEND_ERR : S_CONVERT;
        end
      end

      S_CONVERT: begin
        // The MSB of the 72-bit concatenation falls off; the top digit of a
        // 32-bit value is at most 4, so nothing meaningful is lost.
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_SKIPZ;
        end
      end

      S_SKIPZ: begin
        // Highest non-zero digit wins; an all-zero value leaves idx at 0 so
        // a single '0' is still sent.
        idx_d = 4'd0;
        for (int i = 0; i < 10; i++) begin
          if (bcd_q[i*4 +: 4] != 4'd0) begin
            idx_d = 4'(i);
          end
        end
        state_d = S_SEND_DIGIT;
      end

      S_SEND_DIGIT: begin
        tx_valid = 1'b1;
        tx_data  = 8'h30 + {4'b0000, digit};
        if (tx_ready) begin
          if (idx_q == 4'd0) begin
            state_d = (EMIT_CRLF != 0) ? S_SEND_CR : S_FINISHED;
          end else begin
            idx_d = idx_q - 4'd1;
          end
        end
      end

      S_SEND_ERR: begin
        tx_valid = 1'b1;
        tx_data  = (err_cnt_q == 2'd0) ? 8'h45 : 8'h52;
        if (tx_ready) begin
          if (err_cnt_q == 2'd2) begin
            state_d = (EMIT_CRLF != 0) ? S_SEND_CR : S_FINISHED;
          end else begin
            err_cnt_d = err_cnt_q + 2'd1;
          end
        end
      end

      S_SEND_CR: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0D;
        if (tx_ready) begin
          state_d = S_SEND_LF;
        end
      end

      S_SEND_LF: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0A;
        if (tx_ready) begin
          state_d = S_FINISHED;
        end
      end

      S_FINISHED: begin
        // Terminal until reset: inputs are deliberately ignored here.
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign busy     = (state_q != S_IDLE) && (state_q != S_FINISHED);
  assign finished = (state_q == S_FINISHED);

endmodule
`default_nettype wire

// File: tb/tb_euler_result_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_euler_result_formatter
//  Description : Directed, table-driven bench for euler_result_formatter.
//                Two instances (with and without CR/LF) share all inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_euler_result_formatter;

  logic        clk = 1'b0;
  logic        rst, done, error, tx_ready;
  logic [31:0] result;
  logic [7:0]  tx_data0, tx_data1;
  logic        tx_valid0, tx_valid1, busy0, busy1, fin0, fin1;

  always #5 clk = ~clk;

  euler_result_formatter #(.EMIT_CRLF(1)) u_dut0 (
    .clk(clk), .rst(rst), .result(result), .done(done), .error(error),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
    .busy(busy0), .finished(fin0)
  );

  euler_result_formatter #(.EMIT_CRLF(0)) u_dut1 (
    .clk(clk), .rst(rst), .result(result), .done(done), .error(error),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready),
    .busy(busy1), .finished(fin1)
  );

  typedef struct {
    logic [31:0] result;
    logic        error;
    int          ready_pct;
    string       text;
  } vec_t;

  vec_t        vecs[8];
  int          n_vec = 0;
  int          n_bad = 0;
  byte unsigned got0[$], got1[$];
  int          first_valid;
  int          stab_bad;
  bit          timed_out;
  logic        busy_at0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; done = 1'b0; error = 1'b0; result = '0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Called at a negedge: releases reset, raises done, and collects the
  // accepted bytes of both instances until both report finished.
  task automatic run_line(input logic [31:0] res, input logic err, input int pct);
    logic       pv0, pv1, pr;
    logic [7:0] pd0, pd1;
    bit         end_ok;
    got0.delete(); got1.delete();
    first_valid = -1; stab_bad = 0; timed_out = 1'b0; end_ok = 1'b0;
    pv0 = 1'b0; pv1 = 1'b0; pr = 1'b0; pd0 = '0; pd1 = '0; busy_at0 = 1'b0;
    result = res; error = err; done = 1'b1; rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 0) busy_at0 = busy0;
      // Inputs after capture must have no effect.
      if (cyc == 5) begin result = 32'h5A5A5A5A; error = ~err; done = 1'b0; end
      if (tx_valid0 && first_valid < 0) first_valid = cyc;
      if (pv0 && !pr && (!tx_valid0 || tx_data0 != pd0)) stab_bad++;
      if (pv1 && !pr && (!tx_valid1 || tx_data1 != pd1)) stab_bad++;
      pv0 = tx_valid0; pd0 = tx_data0; pv1 = tx_valid1; pd1 = tx_data1;
      if (fin0 && fin1) begin
        end_ok = 1'b1;
        break;
      end
      tx_ready = (int'($urandom_range(0, 99)) < pct);
      pr = tx_ready;
      if (tx_valid0 && tx_ready) got0.push_back(tx_data0);
      if (tx_valid1 && tx_ready) got1.push_back(tx_data1);
    end
    timed_out = !end_ok;
    tx_ready = 1'b0;
    done = 1'b1;
  endtask

  task automatic check_line(input string name, input string text, input logic err);
    byte unsigned exp0[$], exp1[$];
    for (int i = 0; i < text.len(); i++) begin
      exp0.push_back(text[i]);
      exp1.push_back(text[i]);
    end
    exp0.push_back(8'h0D);
    exp0.push_back(8'h0A);
    chk({name, " timeout"}, timed_out, 0);
    chk({name, " len crlf"}, got0.size(), exp0.size());
    for (int i = 0; i < exp0.size() && i < got0.size(); i++)
      chk($sformatf("%s crlf byte%0d", name, i), got0[i], exp0[i]);
    chk({name, " len nocrlf"}, got1.size(), exp1.size());
    for (int i = 0; i < exp1.size() && i < got1.size(); i++)
      chk($sformatf("%s nocrlf byte%0d", name, i), got1[i], exp1[i]);
    chk({name, " first valid cycle"}, first_valid, err ? 0 : 33);
    chk({name, " busy after capture"}, busy_at0, 1);
    chk({name, " data stable while stalled"}, stab_bad, 0);
    chk({name, " finished"}, fin0, 1);
    chk({name, " busy at end"}, busy0, 0);
  endtask

  initial begin
    int   bad;
    bit   seen;

    vecs[0] = '{32'd31875000,   1'b0, 100, "31875000"};
    vecs[1] = '{32'd0,          1'b0, 100, "0"};
    vecs[2] = '{32'hFFFFFFFF,   1'b0, 100, "4294967295"};
    vecs[3] = '{32'h12345678,   1'b1, 100, "ERR"};
    vecs[4] = '{32'd1000,       1'b0, 30,  "1000"};
    vecs[5] = '{32'd9,          1'b0, 60,  "9"};
    vecs[6] = '{32'd10,         1'b0, 100, "10"};
    vecs[7] = '{32'd1000000000, 1'b1, 30,  "ERR"};

    do_reset();
    chk("reset tx_valid", tx_valid0, 0);
    chk("reset tx_data", tx_data0, 0);
    chk("reset busy", busy0, 0);
    chk("reset finished", fin0, 0);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      run_line(vecs[v].result, vecs[v].error, vecs[v].ready_pct);
      check_line($sformatf("vec%0d", v), vecs[v].text, vecs[v].error);
    end

    // Reset at E10, mid-conversion, then a fresh capture with done held.
    do_reset();
    result = 32'd1000; error = 1'b0; done = 1'b1; rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midconv busy before rst", busy0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midconv rst tx_valid", tx_valid0, 0);
    chk("midconv rst busy", busy0, 0);
    run_line(32'd1000, 1'b0, 100);
    check_line("after midconv rst", "1000", 1'b0);

    // Reset while the first digit is stalled by tx_ready=0.
    do_reset();
    result = 32'd31875000; error = 1'b0; done = 1'b1; rst = 1'b0; tx_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      seen = tx_valid0;
    end
    chk("stall valid seen", seen, 1);
    repeat (3) @(negedge clk);
    chk("stall data held", tx_data0, 8'h33);
    rst = 1'b1;
    @(negedge clk);
    chk("stall rst tx_valid", tx_valid0, 0);
    chk("stall rst busy", busy0, 0);
    chk("stall rst tx_data", tx_data0, 0);
    run_line(32'd31875000, 1'b0, 100);
    check_line("after stall rst", "31875000", 1'b0);

    // Finished is terminal: done held, result changed, ready high.
    done = 1'b1; result = 32'd7; tx_ready = 1'b1; bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx_valid0 || tx_valid1 || !fin0 || !fin1) bad++;
    end
    chk("no retransmit after finished", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
